// File: rtl/instr_decode_pkg.sv
// op_code: opcode enum, instruction field positions and decode-stage types
package op_code;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LD  = 4'd1,
    OP_ST  = 4'd2,
    OP_LDM = 4'd3,
    OP_STM = 4'd4,
    OP_ADD = 4'd5
  } full_operation;
  localparam logic [1:0] DIRECT_LD  = 2'b10;
  localparam logic [1:0] DEFAULT_LD = 2'b00;
  localparam int RF_LSB   = 0;
  localparam int OP_LSB   = 2;
  localparam int MODE_LSB = 6;
  localparam int DMEM_LSB = 6;
  localparam int IMM_LSB  = 8;
  typedef struct packed {
    logic acc_we;
    logic rf_we;
    logic dmem_we;
    logic imm_sel;
    logic illegal;
  } id_ctrl_t;
  typedef enum logic {RUN, STALL} id_state_t;
endpackage

// File: rtl/instr_decode_ctrl_decode.sv
// id_ctrl_decode: combinational opcode/mode to execute-stage enable mapping
module id_ctrl_decode
  import op_code::*;
(
  input  full_operation op,
  input  logic [1:0]    mode,
  output id_ctrl_t      ctrl
);
  assign ctrl = '{
    acc_we:  op inside {OP_LD, OP_LDM, OP_ADD},
    rf_we:   op == OP_ST,
    dmem_we: op == OP_STM,
    imm_sel: op == OP_LD && mode == DIRECT_LD,
    illegal: !(op inside {OP_NOP, OP_LD, OP_ST, OP_LDM, OP_STM, OP_ADD})
  };
endmodule

// File: rtl/instr_decode.sv
// instr_decode: registered decode stage with ready/valid flow and post-LDM bubbles
// ID_ILLEGAL_TRAP_EN: illegal opcodes latch a sticky o_illegal and halt fetch.
module instr_decode
  import op_code::*;
#(
  parameter int LDM_LATENCY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [15:0]   i_instr,
  input  full_operation i_op,
  output logic          o_ready,
  input  logic          i_ex_ready,
  output logic          o_valid,
  output full_operation o_op,
  output logic [1:0]    o_rf_addr,
  output logic [9:0]    o_dmem_addr,
  output logic [7:0]    o_imm,
  output logic          o_imm_sel,
  output logic          o_acc_we,
  output logic          o_rf_we,
  output logic          o_dmem_we,
  output logic          o_illegal
);
`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  id_ctrl_t  c, ctrl_q;
  id_state_t state;
  logic [1:0] cnt;
  logic in_x, out_x, unused_op;
  id_ctrl_decode u_dec (.op(i_op), .mode(i_instr[MODE_LSB +: 2]), .ctrl(c));
  // fetch extracts the opcode itself, so the in-word copy is redundant
  assign unused_op = ^i_instr[OP_LSB +: 4];
  assign o_ready = !i_rst && state == RUN && (!o_valid || i_ex_ready) && !ctrl_q.illegal;
  assign in_x = i_valid && o_ready;
  assign out_x = o_valid && i_ex_ready;
  assign {o_acc_we, o_rf_we, o_dmem_we, o_imm_sel, o_illegal} = ctrl_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_op <= OP_NOP;
      o_rf_addr <= '0;
      o_dmem_addr <= '0;
      o_imm <= '0;
      ctrl_q <= '0;
      state <= RUN;
      cnt <= '0;
    end else begin
      if (in_x) begin
        o_valid <= 1'b1;
        o_op <= c.illegal ? OP_NOP : i_op;
        o_rf_addr <= i_instr[RF_LSB +: 2];
        o_dmem_addr <= i_instr[DMEM_LSB +: 10];
        o_imm <= i_instr[IMM_LSB +: 8];
        ctrl_q <= '{c.acc_we, c.rf_we, c.dmem_we, c.imm_sel, TRAP && c.illegal};
        if (i_op == OP_LDM && LDM_LATENCY > 1) begin
          state <= STALL;
          cnt <= 2'(LDM_LATENCY - 1);
        end
      end else if (out_x) begin
        o_valid <= 1'b0;
        ctrl_q <= '{default: 1'b0, illegal: ctrl_q.illegal};
      end
      // bubble countdown starts with the edge that hands the LDM to execute
      if (state == STALL && (!o_valid || i_ex_ready)) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: randomized and directed checks of instr_decode against a cycle model
module tb_instr_decode;
  import op_code::*;
  localparam int LAT = 2;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_rst, i_valid, i_ex_ready;
  logic [15:0] i_instr;
  full_operation i_op, o_op;
  logic o_ready, o_valid, o_imm_sel, o_acc_we, o_rf_we, o_dmem_we, o_illegal;
  logic [1:0] o_rf_addr;
  logic [9:0] o_dmem_addr;
  logic [7:0] o_imm;
  instr_decode #(.LDM_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_op(i_op),
    .o_ready(o_ready), .i_ex_ready(i_ex_ready), .o_valid(o_valid), .o_op(o_op),
    .o_rf_addr(o_rf_addr), .o_dmem_addr(o_dmem_addr), .o_imm(o_imm), .o_imm_sel(o_imm_sel),
    .o_acc_we(o_acc_we), .o_rf_we(o_rf_we), .o_dmem_we(o_dmem_we), .o_illegal(o_illegal)
  );
  int vecs = 0, errs = 0;
  logic m_valid = 0, m_ill = 0, m_pend = 0, m_ready = 0;
  logic [3:0] m_op = 0, m_en = 0;
  logic [1:0] m_rf = 0;
  logic [9:0] m_dmem = 0;
  logic [7:0] m_imm = 0;
  int m_wait = 0;
  wire [29:0] dut_vec = {o_valid, o_op, o_rf_addr, o_dmem_addr, o_imm,
                         o_acc_we, o_rf_we, o_dmem_we, o_imm_sel, o_illegal};
  function automatic logic [29:0] exp_vec();
    return {m_valid, m_op, m_rf, m_dmem, m_imm, m_en, m_ill};
  endfunction
  // {acc_we, rf_we, dmem_we, imm_sel} demanded by each opcode
  function automatic logic [3:0] en_of(logic [3:0] op, logic [1:0] mode);
    case (op)
      OP_LD:   return {3'b100, mode == 2'b10};
      OP_ST:   return 4'b0100;
      OP_LDM:  return 4'b1000;
      OP_STM:  return 4'b0010;
      OP_ADD:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic legal(logic [3:0] op);
    return op == OP_NOP || en_of(op, 2'b00) != 4'b0;
  endfunction
  function automatic logic [15:0] mk(logic [3:0] op, logic [9:0] hi, logic [1:0] rf);
    return {hi, op, rf};
  endfunction
  task automatic apply(input bit r, input bit v, input logic [15:0] w, input bit exr);
    i_rst = r; i_valid = v; i_instr = w; i_op = full_operation'(w[5:2]); i_ex_ready = exr;
    #1;
    m_ready = !r && !m_pend && m_wait == 0 && (!m_valid || exr) && !m_ill;
  endtask
  task automatic tick();
    logic acc, outx, lg;
    @(posedge clk);
    acc = i_valid && m_ready;
    outx = m_valid && i_ex_ready;
    if (i_rst) begin
      m_valid = 0; m_op = OP_NOP; m_rf = 0; m_dmem = 0; m_imm = 0; m_en = 0;
      m_ill = 0; m_pend = 0; m_wait = 0;
    end else begin
      if (m_wait > 0 && !m_pend) m_wait--;
      if (m_pend && outx) begin m_pend = 0; m_wait = LAT - 2; end
      if (acc) begin
        lg = legal(i_instr[5:2]);
        m_valid = 1; m_op = lg ? i_instr[5:2] : OP_NOP;
        m_rf = i_instr[1:0]; m_dmem = i_instr[15:6]; m_imm = i_instr[15:8];
        m_en = en_of(i_instr[5:2], i_instr[7:6]);
        m_ill = m_ill || (TRAP && !lg);
        m_pend = i_instr[5:2] == OP_LDM && LAT > 1;
      end else if (outx) begin
        m_valid = 0; m_en = 0;
      end
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    apply(1, 1, mk(OP_LD, 10'h3FA, 2'd1), 1);
    vecs++;
    if (o_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    tick();
    apply(0, 0, 16'h0, 1);
    vecs++;
    if (dut_vec !== exp_vec() || o_ready !== 1'b1 || o_valid !== 1'b0 || o_op !== OP_NOP) begin
      errs++; $display("FAIL reset_state: got %h rdy %b want %h rdy 1", dut_vec, o_ready, exp_vec());
    end
  endtask
  task automatic test_ld_imm();
    apply(0, 1, {8'hFE, 2'b10, OP_LD, 2'b11}, 1);
    tick();
    apply(0, 0, 16'h0, 1);
    vecs++;
    if (o_valid !== 1 || o_imm !== 8'hFE || o_imm_sel !== 1 || o_acc_we !== 1 || o_rf_addr !== 2'd3
        || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL ld_imm: got %h want %h", dut_vec, exp_vec());
    end
    tick();
  endtask
  task automatic test_stream();
    logic [15:0] w [4];
    logic [2:0] en [5];
    w = '{mk(OP_NOP, 10'h155, 2'd2), mk(OP_ST, 10'h2AA, 2'd3), mk(OP_STM, 10'd1, 2'd0),
          mk(OP_ADD, 10'h0F0, 2'd1)};
    en = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 5; i++) begin
      apply(0, i < 4, i < 4 ? w[i] : 16'h0, 1);
      vecs++;
      if (dut_vec !== exp_vec() || o_ready !== m_ready || (i > 0 && o_valid !== 1'b1)
          || (i > 0 && {o_acc_we, o_rf_we, o_dmem_we} !== en[i]) || (i == 3 && o_dmem_addr !== 10'd1)) begin
        errs++; $display("FAIL stream[%0d]: got %h rdy %b want %h rdy %b", i, dut_vec, o_ready, exp_vec(), m_ready);
      end
      tick();
    end
  endtask
  task automatic test_ldm();
    int nr = 0, bub = 0;
    bit got = 0;
    apply(0, 1, mk(OP_LDM, 10'd5, 2'd0), 1);
    tick();
    for (int k = 0; k < 10 && !got; k++) begin
      apply(0, 1, mk(OP_ADD, 10'h011, 2'd2), 1);
      vecs++;
      if (dut_vec !== exp_vec() || o_ready !== m_ready) begin
        errs++; $display("FAIL ldm_cycle[%0d]: got %h rdy %b want %h rdy %b", k, dut_vec, o_ready, exp_vec(), m_ready);
      end
      if (!o_ready) nr++;
      if (!o_valid) bub++;
      tick();
      got = o_valid && o_op == OP_ADD;
    end
    vecs++;
    if (!got || nr != LAT - 1 || bub != LAT - 1) begin
      errs++; $display("FAIL ldm_bubble: add_seen %b stall %0d bubbles %0d want 1/%0d/%0d", got, nr, bub, LAT - 1, LAT - 1);
    end
    apply(0, 0, 16'h0, 1);
    tick();
  endtask
  task automatic test_backpressure();
    logic [29:0] snap;
    apply(0, 1, mk(OP_ADD, 10'h2C3, 2'd1), 1);
    tick();
    snap = dut_vec;
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, mk(OP_ST, 10'h0AB, 2'd2), 0);
      vecs++;
      if (o_ready !== 0 || dut_vec !== snap || o_op !== OP_ADD || dut_vec !== exp_vec()) begin
        errs++; $display("FAIL backpressure[%0d]: got %h rdy %b want %h rdy 0", k, dut_vec, o_ready, exp_vec());
      end
      tick();
    end
    apply(0, 1, mk(OP_ST, 10'h0AB, 2'd2), 1);
    vecs++;
    if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
    tick();
    apply(0, 0, 16'h0, 1);
    vecs++;
    if (o_valid !== 1 || o_op !== OP_ST || o_rf_we !== 1 || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL bp_next: got %h want %h", dut_vec, exp_vec());
    end
    tick();
  endtask
  task automatic test_illegal();
    logic exp_ill = TRAP;
    apply(0, 1, mk(4'hB, 10'h3C7, 2'd3), 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, mk(OP_ADD, 10'h001, 2'd0), 1);
      vecs++;
      if (dut_vec !== exp_vec() || o_ready !== m_ready || o_illegal !== exp_ill || o_ready !== (k == 0 ? !exp_ill : 1'b1)) begin
        errs++; $display("FAIL illegal[%0d]: got %h rdy %b want %h rdy %b", k, dut_vec, o_ready, exp_vec(), m_ready);
      end
      tick();
    end
    apply(1, 0, 16'h0, 1);
    tick();
    apply(0, 0, 16'h0, 1);
    vecs++;
    if (o_illegal !== 0 || o_ready !== 1) begin
      errs++; $display("FAIL illegal_clear: ill %b rdy %b want 0/1", o_illegal, o_ready);
    end
  endtask
  task automatic test_reset_stall();
    apply(0, 1, mk(OP_LDM, 10'd9, 2'd1), 0);
    tick();
    apply(1, 1, mk(OP_ADD, 10'd0, 2'd0), 0);
    tick();
    apply(0, 1, mk(OP_ADD, 10'd3, 2'd2), 0);
    vecs++;
    if (o_ready !== 1'b1 || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL reset_stall: got %h rdy %b want %h rdy 1", dut_vec, o_ready, exp_vec());
    end
    tick();
  endtask
  task automatic test_random();
    logic [3:0] op;
    for (int k = 0; k < 600; k++) begin
      op = 4'($urandom_range(0, TRAP ? 5 : 15));
      apply($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            mk(op, 10'($urandom), 2'($urandom)), $urandom_range(0, 3) != 0);
      vecs++;
      if (dut_vec !== exp_vec() || o_ready !== m_ready) begin
        errs++; $display("FAIL random[%0d]: got %h rdy %b want %h rdy %b", k, dut_vec, o_ready, exp_vec(), m_ready);
      end
      tick();
    end
  endtask
  initial begin
    i_rst = 1; i_valid = 0; i_instr = 0; i_op = OP_NOP; i_ex_ready = 1;
    @(negedge clk);
    test_reset();
    test_ld_imm();
    test_stream();
    test_ldm();
    test_backpressure();
    test_reset_stall();
    test_random();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
